// File: rtl/shift_reg_pe_ar_pkg.sv
// Shared definitions for the universal shift register: manual op encodings,
// burst FSM states, burst direction constants and a direction->op helper.
package shift_reg_pe_ar_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_ROTL = 3'b011,
    MODE_ROTR = 3'b100,
    MODE_LOAD = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  // Burst shifts reuse the manual shl/shr datapath.
  function automatic mode_e dir_to_op(input logic dir);
    return (dir == DIR_R) ? MODE_SHR : MODE_SHL;
  endfunction

endpackage

// File: rtl/shift_reg_pe_ar_shift_next_val.sv
// Combinational next-value function shared by the manual and burst paths.
// Ports:
//   q      current register value
//   op     operation (mode_e encoding)
//   sin_l  serial bit entering LSB on shl
//   sin_r  serial bit entering MSB on shr
//   d      parallel load data
//   q_next resulting value
module shift_next_val
  import shift_reg_pe_ar_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic [WIDTH-1:0] q,
  input  mode_e            op,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    unique case (op)
      MODE_SHL:  q_next = {q[WIDTH-2:0], sin_l};
      MODE_SHR:  q_next = {sin_r, q[WIDTH-1:1]};
      MODE_ROTL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROTR: q_next = {q[0], q[WIDTH-1:1]};
      MODE_LOAD: q_next = d;
      MODE_CLR:  q_next = RST_VAL;
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/shift_reg_pe_ar.sv
// Parametrised universal shift register with async active-low reset,
// manual modes (hold/shl/shr/rotl/rotr/load/clear) and a burst-shift engine.
// Ports:
//   clk, rst          clock, async active-low reset
//   en                clock enable (done still clears when low)
//   mode, d           manual op select and parallel load data
//   sin_l, sin_r      serial inputs for shl / shr
//   start, dir, len   burst request, direction, shift count (clamped to WIDTH)
//   q                 register contents
//   sout_msb/sout_lsb q[WIDTH-1] / q[0]
//   busy, done        burst in progress / one-cycle completion pulse
module shift_reg_pe_ar
  import shift_reg_pe_ar_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               LW      = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic             dir,
  input  logic [LW-1:0]    len,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  state_e          state;
  logic [LW-1:0]   cnt;
  logic            dir_q;
  logic            armed;   // low on the edge that releases reset: no op there
  logic [WIDTH-1:0] q_next;
  logic [LW-1:0]   len_c;
  mode_e           op;

  assign len_c = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;
  assign op    = (state == ST_SHIFT) ? dir_to_op(dir_q) : mode_e'(mode);

  shift_next_val #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_nv (
    .q      (q),
    .op     (op),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .d      (d),
    .q_next (q_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q     <= RST_VAL;
      state <= ST_IDLE;
      cnt   <= '0;
      dir_q <= DIR_L;
      done  <= 1'b0;
      armed <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!armed) begin
        armed <= 1'b1;
      end else if (en) begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              // start wins over mode; q holds on the accepting edge
              dir_q <= dir;
              if (len_c == '0) begin
                done <= 1'b1;
              end else begin
                cnt   <= len_c;
                state <= ST_SHIFT;
              end
            end else begin
              q <= q_next;
            end
          end
          ST_SHIFT: begin
            q   <= q_next;
            cnt <= cnt - 1'b1;
            if (cnt == LW'(1)) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy     = (state == ST_SHIFT);
  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];

endmodule

// File: tb/tb_shift_reg_pe_ar.sv
module tb_shift_reg_pe_ar;
  import shift_reg_pe_ar_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, sin_l, sin_r, start, dir;
  logic [2:0] mode;
  logic [7:0] d;
  logic [3:0] len;
  logic [7:0] q, q2;
  logic       smsb, slsb, busy, done, smsb2, slsb2, busy2, done2;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: remaining shift count, no state encoding
  logic [7:0] m_q;
  int         m_rem;
  logic       m_dir, m_done, m_arm;

  always #5 clk = ~clk;

  shift_reg_pe_ar #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin_l(sin_l),
    .sin_r(sin_r), .start(start), .dir(dir), .len(len), .q(q),
    .sout_msb(smsb), .sout_lsb(slsb), .busy(busy), .done(done));

  shift_reg_pe_ar #(.WIDTH(8), .RST_VAL(8'h3C)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin_l(sin_l),
    .sin_r(sin_r), .start(start), .dir(dir), .len(len), .q(q2),
    .sout_msb(smsb2), .sout_lsb(slsb2), .busy(busy2), .done(done2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] f_shl(input logic [7:0] v, input logic b);
    return 8'(({24'h0, v} * 2 + {31'h0, b}) % 256);
  endfunction

  function automatic logic [7:0] f_shr(input logic [7:0] v, input logic b);
    return 8'(({24'h0, v} / 2) + (b ? 128 : 0));
  endfunction

  task automatic drv(input logic e, input logic [2:0] m, input logic [7:0] dd,
                     input logic sl, input logic sr, input logic st,
                     input logic dr, input logic [3:0] ln);
    en = e; mode = m; d = dd; sin_l = sl; sin_r = sr; start = st; dir = dr; len = ln;
  endtask

  task automatic model_edge();
    int c;
    m_done = 1'b0;
    if (!m_arm) m_arm = 1'b1;
    else if (en) begin
      if (m_rem == 0) begin
        if (start) begin
          c = (int'(len) > 8) ? 8 : int'(len);
          if (c == 0) m_done = 1'b1;
          else begin m_rem = c; m_dir = dir; end
        end else begin
          case (mode)
            3'd1: m_q = f_shl(m_q, sin_l);
            3'd2: m_q = f_shr(m_q, sin_r);
            3'd3: m_q = f_shl(m_q, m_q[7]);
            3'd4: m_q = f_shr(m_q, m_q[0]);
            3'd5: m_q = d;
            3'd6: m_q = 8'h00;
            default: ;
          endcase
        end
      end else begin
        m_q = m_dir ? f_shr(m_q, sin_r) : f_shl(m_q, sin_l);
        m_rem--;
        if (m_rem == 0) m_done = 1'b1;
      end
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk); #1;
    chk({tag, ".q"}, {24'h0, q}, {24'h0, m_q});
    chk({tag, ".busy"}, {31'h0, busy}, {31'h0, (m_rem != 0)});
    chk({tag, ".done"}, {31'h0, done}, {31'h0, m_done});
    chk({tag, ".sout"}, {30'h0, smsb, slsb}, {30'h0, m_q[7], m_q[0]});
  endtask

  // async reset asserted mid-cycle, checked before any edge, released mid-cycle
  task automatic do_reset(input string tag);
    #3 rst = 1'b0;
    #1;
    m_q = 8'h00; m_rem = 0; m_done = 1'b0; m_arm = 1'b0;
    chk({tag, ".q"}, {24'h0, q}, 32'h00);
    chk({tag, ".busy"}, {31'h0, busy}, 32'h0);
    chk({tag, ".done"}, {31'h0, done}, 32'h0);
    chk({tag, ".q2"}, {24'h0, q2}, 32'h3C);
    chk({tag, ".busy2"}, {31'h0, busy2}, 32'h0);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    drv(0, MODE_HOLD, 8'h00, 0, 0, 0, 0, 0);
    m_q = 8'h00; m_rem = 0; m_dir = 1'b0; m_done = 1'b0; m_arm = 1'b0;
    #22;
    chk("init.q", {24'h0, q}, 32'h00);
    chk("init.q2", {24'h0, q2}, 32'h3C);
    chk("init.busy", {31'h0, busy}, 32'h0);
    rst = 1'b1;
    tick("release");

    // async reset from a loaded value
    drv(1, MODE_LOAD, 8'hA5, 0, 0, 0, 0, 0); tick("ld_a5");
    do_reset("arst");
    drv(1, MODE_HOLD, 8'h00, 0, 0, 0, 0, 0); tick("post_rst");

    // manual modes
    drv(1, MODE_LOAD, 8'hA5, 0, 0, 0, 0, 0); tick("ld");
    drv(1, MODE_ROTL, 8'h00, 0, 0, 0, 0, 0); tick("rotl"); chk("rotl_k", {24'h0, q}, 32'h4B);
    drv(1, MODE_ROTR, 8'h00, 0, 0, 0, 0, 0); tick("rotr"); chk("rotr_k", {24'h0, q}, 32'hA5);
    drv(1, MODE_SHL,  8'h00, 1, 0, 0, 0, 0); tick("shl");  chk("shl_k", {24'h0, q}, 32'h4B);
    drv(1, MODE_SHR,  8'h00, 0, 0, 0, 0, 0); tick("shr");  chk("shr_k", {24'h0, q}, 32'h25);
    drv(1, MODE_CLR,  8'h00, 0, 0, 0, 0, 0); tick("clr");  chk("clr_k", {24'h0, q}, 32'h00);
    drv(0, MODE_LOAD, 8'hFF, 0, 0, 0, 0, 0); tick("en0");  chk("en0_k", {24'h0, q}, 32'h00);

    // burst shl len=3, load ignored while busy
    drv(1, MODE_LOAD, 8'h81, 0, 0, 0, 0, 0); tick("ld81");
    drv(1, MODE_HOLD, 8'h00, 0, 0, 1, DIR_L, 3); tick("b_e0");
    chk("b_e0_busy", {31'h0, busy}, 32'h1);
    drv(1, MODE_LOAD, 8'hFF, 0, 0, 0, 0, 0);
    tick("b_e1"); chk("b_e1_k", {24'h0, q}, 32'h02);
    tick("b_e2"); chk("b_e2_k", {24'h0, q}, 32'h04);
    tick("b_e3"); chk("b_e3_k", {24'h0, q}, 32'h08);
    chk("b_done_k", {31'h0, done}, 32'h1);
    drv(1, MODE_HOLD, 8'h00, 0, 0, 0, 0, 0); tick("b_after");
    chk("b_done_off", {31'h0, done}, 32'h0);

    // len=0: immediate done, never busy
    drv(1, MODE_HOLD, 8'h00, 0, 0, 1, DIR_L, 0); tick("len0");
    chk("len0_done", {31'h0, done}, 32'h1);
    chk("len0_busy", {31'h0, busy}, 32'h0);
    drv(1, MODE_HOLD, 8'h00, 0, 0, 0, 0, 0); tick("len0_after");

    // len=9 clamps to 8, shr sin_r=1 from 0
    drv(1, MODE_CLR, 8'h00, 0, 0, 0, 0, 0); tick("clr9");
    drv(1, MODE_HOLD, 8'h00, 0, 1, 1, DIR_R, 9); tick("len9_e0");
    drv(1, MODE_HOLD, 8'h00, 0, 1, 0, 0, 0);
    repeat (8) tick("len9");
    chk("len9_k", {24'h0, q}, 32'hFF);
    chk("len9_done", {31'h0, done}, 32'h1);
    tick("len9_after");

    // stall: en low two cycles after 2nd shift
    drv(1, MODE_HOLD, 8'h00, 1, 0, 1, DIR_L, 4); tick("st_e0");
    drv(1, MODE_HOLD, 8'h00, 1, 0, 0, 0, 0); tick("st_e1"); tick("st_e2");
    drv(0, MODE_HOLD, 8'h00, 1, 0, 0, 0, 0); tick("st_hold1"); tick("st_hold2");
    chk("st_busy", {31'h0, busy}, 32'h1);
    drv(1, MODE_HOLD, 8'h00, 1, 0, 0, 0, 0); tick("st_e3"); tick("st_e4");
    chk("st_done", {31'h0, done}, 32'h1);
    tick("st_after");

    // abort mid-burst
    drv(1, MODE_HOLD, 8'h00, 0, 1, 1, DIR_R, 4); tick("ab_e0");
    drv(1, MODE_HOLD, 8'h00, 0, 1, 0, 0, 0); tick("ab_e1"); tick("ab_e2");
    do_reset("abort");
    tick("ab_rel"); tick("ab_a1"); tick("ab_a2");

    // back-to-back bursts
    drv(1, MODE_LOAD, 8'h3A, 0, 0, 0, 0, 0); tick("bb_ld");
    drv(1, MODE_HOLD, 8'h00, 1, 0, 1, DIR_L, 2); tick("bb_e0");
    drv(1, MODE_HOLD, 8'h00, 1, 0, 0, 0, 0); tick("bb_e1"); tick("bb_e2");
    chk("bb_done1", {31'h0, done}, 32'h1);
    drv(1, MODE_HOLD, 8'h00, 0, 1, 1, DIR_R, 2); tick("bb_restart");
    chk("bb_busy2", {31'h0, busy}, 32'h1);
    drv(1, MODE_HOLD, 8'h00, 0, 1, 0, 0, 0); tick("bb_f1"); tick("bb_f2");
    chk("bb_done2", {31'h0, done}, 32'h1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drv(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
          1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
          1'($urandom), 4'($urandom_range(0, 15)));
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
